// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter branch predictor with
// mispredict flagging and branch/mispredict statistics.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pred_pc,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic             upd_pred,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int ENTRIES = 2 ** INDEX_BITS;

    logic [1:0]            table_q [ENTRIES];
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [1:0]            ctr_cur;
    logic [1:0]            ctr_d;
    logic                  misp_d, misp_q;
    logic [CNT_W-1:0]      bc_d, bc_q;
    logic [CNT_W-1:0]      mc_d, mc_q;
    logic                  unused_pc_bits;

    assign pred_idx = pred_pc[INDEX_BITS+1:2];
    assign upd_idx  = upd_pc[INDEX_BITS+1:2];

    // Word-offset and high PC bits do not take part in indexing.
    assign unused_pc_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0],
                              upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

    // Read is the pre-update value; no bypass from the write port.
    assign pred_taken = table_q[pred_idx][1];

    always_comb begin
        ctr_cur = table_q[upd_idx];
        ctr_d   = ctr_cur;
        if (upd_taken) begin
            if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'd1;
        end
        misp_d = upd_valid & (upd_pred ^ upd_taken);
        bc_d   = bc_q;
        mc_d   = mc_q;
        if (upd_valid) begin
            bc_d = bc_q + CNT_W'(1);
            if (misp_d) mc_d = mc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b01;
            end
            misp_q <= 1'b0;
            bc_q   <= '0;
            mc_q   <= '0;
        end else begin
            if (upd_valid) table_q[upd_idx] <= ctr_d;
            misp_q <= misp_d;
            bc_q   <= bc_d;
            mc_q   <= mc_d;
        end
    end

    assign mispredict       = misp_q;
    assign branch_count     = bc_q;
    assign mispredict_count = mc_q;

endmodule
